// File: rtl/spmv_fp16_pkg.sv
// rtl/spmv_fp16_pkg.sv - FP16 constants, field widths and stage-1 record for the SpMV multiplier
package spmv_fp16_pkg;

    localparam int FP16_SIGN_W = 1;
    localparam int FP16_EXP_W  = 5;
    localparam int FP16_MAN_W  = 10;
    localparam int FP16_W      = FP16_SIGN_W + FP16_EXP_W + FP16_MAN_W;
    localparam int FP16_PROD_W = 2 * (FP16_MAN_W + 1);
    localparam int FP16_TAG_W  = 8;

    localparam int                    FP16_BIAS    = 15;
    localparam logic [FP16_EXP_W-1:0] FP16_EXP_MAX = 5'h1F;
    localparam logic [FP16_W-1:0]     FP16_QNAN    = 16'h7E00;
    localparam logic [FP16_W-1:0]     FP16_ZERO    = 16'h0000;

    // Everything stage 2 needs to pick and normalise the result.
    typedef struct packed {
        logic                      sign;
        logic signed [6:0]         exp_sum;
        logic [FP16_PROD_W-1:0]    prod;
        logic                      a_zero;
        logic                      a_inf;
        logic                      a_nan;
        logic                      b_zero;
        logic                      b_inf;
        logic                      b_nan;
        logic [FP16_TAG_W-1:0]     tag;
    } s1_t;

endpackage

// File: rtl/spmv_fp16_mul_if.sv
// rtl/spmv_fp16_mul_if.sv - operand-in / product-out handshake bundle of the FP16 multiplier
interface spmv_fp16_mul_if
    import spmv_fp16_pkg::*;
#(
    parameter int TAG_W = FP16_TAG_W
) ();

    logic               i_valid;
    logic               o_ready;
    logic [FP16_W-1:0]  i_a;
    logic [FP16_W-1:0]  i_b;
    logic [TAG_W-1:0]   i_tag;
    logic               o_valid;
    logic               i_out_ready;
    logic [FP16_W-1:0]  o_result;
    logic [TAG_W-1:0]   o_tag;

    modport master (
        output i_valid, i_a, i_b, i_tag, i_out_ready,
        input  o_ready, o_valid, o_result, o_tag
    );

    modport slave (
        input  i_valid, i_a, i_b, i_tag, i_out_ready,
        output o_ready, o_valid, o_result, o_tag
    );

endinterface

// File: rtl/spmv_fp16_classify.sv
// rtl/spmv_fp16_classify.sv - per-operand FP16 class flags and hidden-bit mantissa
module spmv_fp16_classify
    import spmv_fp16_pkg::*;
(
    input  logic [FP16_W-1:0]     op,
    output logic                  is_zero,
    output logic                  is_inf,
    output logic                  is_nan,
    output logic [FP16_MAN_W:0]   man_h
);

    logic [FP16_EXP_W-1:0] exp_f;
    logic [FP16_MAN_W-1:0] man_f;
    logic                  exp_max;

    assign exp_f   = op[FP16_W-2 -: FP16_EXP_W];
    assign man_f   = op[FP16_MAN_W-1:0];
    assign exp_max = (exp_f == FP16_EXP_MAX);

    // Exponent 0 counts as zero: denormals are flushed.
    assign is_zero = (exp_f == '0);
    assign is_inf  = exp_max && (man_f == '0);
    assign is_nan  = exp_max && (man_f != '0);
    assign man_h   = {!is_zero, man_f};

endmodule

// File: rtl/spmv_fp16_mul.sv
// rtl/spmv_fp16_mul.sv - two-stage truncating FP16 multiplier with tag sideband and valid/ready
module spmv_fp16_mul
    import spmv_fp16_pkg::*;
#(
    parameter int TAG_W = FP16_TAG_W
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    spmv_fp16_mul_if.slave   bus
);

    logic                  adv1;
    logic                  adv2;
    logic                  s1_valid;
    s1_t                   s1_q;
    s1_t                   s1_d;
    logic                  o_valid_q;
    logic [FP16_W-1:0]     o_result_q;
    logic [TAG_W-1:0]      o_tag_q;

    logic                  a_zero, a_inf, a_nan;
    logic                  b_zero, b_inf, b_nan;
    logic [FP16_MAN_W:0]   a_man_h, b_man_h;

    logic signed [7:0]     exp_n;
    logic [FP16_MAN_W-1:0] man_n;
    logic                  a_spec, b_spec;
    logic [FP16_W-1:0]     res_d;

    spmv_fp16_classify u_cls_a (
        .op      (bus.i_a),
        .is_zero (a_zero),
        .is_inf  (a_inf),
        .is_nan  (a_nan),
        .man_h   (a_man_h)
    );

    spmv_fp16_classify u_cls_b (
        .op      (bus.i_b),
        .is_zero (b_zero),
        .is_inf  (b_inf),
        .is_nan  (b_nan),
        .man_h   (b_man_h)
    );

    // A stage may move when the stage after it is empty or is being emptied this cycle.
    assign adv2        = !o_valid_q || bus.i_out_ready;
    assign adv1        = !s1_valid || adv2;
    assign bus.o_ready = adv1;

    // Stage-1 record: sign, biased exponent sum, raw mantissa product and class flags.
    always_comb begin
        s1_d         = '0;
        s1_d.sign    = bus.i_a[FP16_W-1] ^ bus.i_b[FP16_W-1];
        s1_d.exp_sum = $signed({2'b00, bus.i_a[FP16_W-2 -: FP16_EXP_W]})
                     + $signed({2'b00, bus.i_b[FP16_W-2 -: FP16_EXP_W]})
                     - 7'(FP16_BIAS);
        s1_d.prod    = {11'b0, a_man_h} * {11'b0, b_man_h};
        s1_d.a_zero  = a_zero;
        s1_d.a_inf   = a_inf;
        s1_d.a_nan   = a_nan;
        s1_d.b_zero  = b_zero;
        s1_d.b_inf   = b_inf;
        s1_d.b_nan   = b_nan;
        s1_d.tag     = FP16_TAG_W'(bus.i_tag);
    end

    // Stage 1 register: data only loads from an accepted operand pair.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (adv1) begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Normalise by at most one place, then resolve specials in priority order.
    always_comb begin
        a_spec = s1_q.a_inf || s1_q.a_nan;
        b_spec = s1_q.b_inf || s1_q.b_nan;
        exp_n  = $signed({s1_q.exp_sum[6], s1_q.exp_sum})
               + $signed({7'b0, s1_q.prod[FP16_PROD_W-1]});
        man_n  = s1_q.prod[FP16_PROD_W-1] ? s1_q.prod[20:11] : s1_q.prod[19:10];
        res_d  = {s1_q.sign, exp_n[FP16_EXP_W-1:0], man_n};
        if (s1_q.a_nan || s1_q.b_nan || (a_spec && s1_q.b_zero) || (b_spec && s1_q.a_zero)) begin
            res_d = FP16_QNAN;
        end else if (a_spec || b_spec) begin
            res_d = {s1_q.sign, FP16_EXP_MAX, {FP16_MAN_W{1'b0}}};
        end else if (s1_q.a_zero || s1_q.b_zero) begin
            res_d = FP16_ZERO;
        end else if (exp_n >= 8'sd31) begin
            res_d = {s1_q.sign, FP16_EXP_MAX, {FP16_MAN_W{1'b0}}};
        end else if (exp_n <= 8'sd0) begin
            res_d = FP16_ZERO;
        end
    end

    // Output register: holds result and tag steady while downstream stalls.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            o_valid_q  <= 1'b0;
            o_result_q <= FP16_ZERO;
            o_tag_q    <= '0;
        end else if (adv2) begin
            o_valid_q <= s1_valid;
            if (s1_valid) begin
                o_result_q <= res_d;
                o_tag_q    <= TAG_W'(s1_q.tag);
            end
        end
    end

    assign bus.o_valid  = o_valid_q;
    assign bus.o_result = o_result_q;
    assign bus.o_tag    = o_tag_q;

endmodule

// File: tb/tb_spmv_fp16_mul.sv
// tb/tb_spmv_fp16_mul.sv - directed and scoreboarded checks of spmv_fp16_mul
module tb_spmv_fp16_mul;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  tag;
    } exp_t;

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   out_cnt;
    int   acc_cnt;
    int   run_len;
    int   max_run;
    exp_t exp_q[$];

    logic [15:0] sa[8];
    logic [15:0] sb[8];

    spmv_fp16_mul_if #(.TAG_W(8)) bus ();

    spmv_fp16_mul #(.TAG_W(8)) u_dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, p, e, m;
        logic s;
        s  = a[15] ^ b[15];
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = int'(a[9:0]);
        mb = int'(b[9:0]);
        if ((ea == 31 && ma != 0) || (eb == 31 && mb != 0)) return 16'h7E00;
        if ((ea == 31 && eb == 0) || (eb == 31 && ea == 0)) return 16'h7E00;
        if (ea == 31 || eb == 31) return {s, 15'h7C00};
        if (ea == 0 || eb == 0) return 16'h0000;
        p = (1024 + ma) * (1024 + mb);
        e = ea + eb - 15;
        if (p >= (1 << 21)) begin
            e = e + 1;
            m = (p >> 11) & 1023;
        end else begin
            m = (p >> 10) & 1023;
        end
        if (e >= 31) return {s, 15'h7C00};
        if (e <= 0) return 16'h0000;
        return {s, 5'(e), 10'(m)};
    endfunction

    function automatic logic [15:0] rnd_fp16(input int i);
        if (i % 5 == 0) return 16'($urandom);
        return {1'($urandom), 5'($urandom_range(6, 24)), 10'($urandom)};
    endfunction

    // Scoreboard: sample the handshake half a cycle before the edge that commits it.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            exp_q.delete();
            run_len = 0;
        end else begin
            if (bus.o_valid && bus.i_out_ready) begin
                out_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (exp_q.size() == 0) begin
                    chk("sb_extra_out", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_result", 32'(bus.o_result), 32'(e.res));
                    chk("sb_tag", 32'(bus.o_tag), 32'(e.tag));
                end
            end else begin
                run_len = 0;
            end
            if (bus.i_valid && bus.o_ready) begin
                acc_cnt++;
                e.res = ref_mul(bus.i_a, bus.i_b);
                e.tag = bus.i_tag;
                exp_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [15:0] a, input logic [15:0] b, input logic [7:0] tg,
                       input logic [15:0] want, input string nm);
        bus.i_a         = a;
        bus.i_b         = b;
        bus.i_tag       = tg;
        bus.i_valid     = 1'b1;
        bus.i_out_ready = 1'b1;
        chk({nm, "_rdy"}, 32'(bus.o_ready), 32'd1);
        step();
        bus.i_valid = 1'b0;
        chk({nm, "_v1"}, 32'(bus.o_valid), 32'd0);
        step();
        chk({nm, "_v2"}, 32'(bus.o_valid), 32'd1);
        chk(nm, 32'(bus.o_result), 32'(want));
        chk({nm, "_tag"}, 32'(bus.o_tag), 32'(tg));
        step();
    endtask

    // Offer item k for one cycle; advance k if it was taken at this edge.
    task automatic offer(inout int k, input logic [7:0] tag_base);
        logic acc;
        bus.i_a     = sa[k];
        bus.i_b     = sb[k];
        bus.i_tag   = tag_base + 8'(k);
        bus.i_valid = 1'b1;
        @(negedge clk);
        acc = bus.o_ready;
        step();
        if (acc) k++;
    endtask

    initial begin
        int c_out, c_acc, k;
        total = 0; bad = 0; out_cnt = 0; acc_cnt = 0; run_len = 0; max_run = 0;
        rstn = 1'b0;
        bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_tag = '0; bus.i_out_ready = 1'b0;
        step(); step();
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_result", 32'(bus.o_result), 32'h0000);
        chk("rst_tag", 32'(bus.o_tag), 32'd0);
        rstn = 1'b1;
        step();

        one(16'h3C00, 16'h3C00, 8'h05, 16'h3C00, "one_x_one");
        one(16'h3E00, 16'h3E00, 8'h11, 16'h4080, "p15_sq");
        one(16'hC000, 16'h3800, 8'h12, 16'hBC00, "neg_half");
        one(16'h7BFF, 16'h7BFF, 8'h13, 16'h7C00, "ovf");
        one(16'h0400, 16'h0400, 8'h14, 16'h0000, "unf");
        one(16'h0001, 16'h3C00, 8'h15, 16'h0000, "denorm");
        one(16'h7C00, 16'h0000, 8'h16, 16'h7E00, "inf_x_0");
        one(16'hFC00, 16'h3C00, 8'h17, 16'hFC00, "ninf");

        // Back-to-back stream at full rate
        bus.i_out_ready = 1'b1;
        max_run = 0;
        c_out = out_cnt;
        for (int i = 0; i < 16; i++) begin
            bus.i_a     = rnd_fp16(i);
            bus.i_b     = rnd_fp16(i + 1);
            bus.i_tag   = 8'h20 + 8'(i);
            bus.i_valid = 1'b1;
            step();
        end
        bus.i_valid = 1'b0;
        repeat (3) step();
        chk("b2b_count", 32'(out_cnt - c_out), 32'd16);
        chk("b2b_run", 32'(max_run), 32'd16);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Downstream stall then release
        for (int i = 0; i < 8; i++) begin
            sa[i] = rnd_fp16(i + 2);
            sb[i] = rnd_fp16(i + 3);
        end
        bus.i_out_ready = 1'b0;
        c_acc = acc_cnt;
        c_out = out_cnt;
        k = 0;
        for (int c = 1; c <= 5; c++) begin
            offer(k, 8'h40);
            if (c >= 2) begin
                chk("stall_valid", 32'(bus.o_valid), 32'd1);
                chk("stall_hold", 32'(bus.o_result), 32'(ref_mul(sa[0], sb[0])));
                chk("stall_hold_tag", 32'(bus.o_tag), 32'h40);
            end
        end
        chk("stall_acc", 32'(acc_cnt - c_acc), 32'd2);
        chk("stall_rdy", 32'(bus.o_ready), 32'd0);
        bus.i_out_ready = 1'b1;
        for (int c = 0; c < 20 && k < 6; c++) offer(k, 8'h40);
        chk("stall_offered", 32'(k), 32'd6);
        bus.i_valid = 1'b0;
        repeat (4) step();
        chk("stall_out", 32'(out_cnt - c_out), 32'd6);
        chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two items in flight
        c_out = out_cnt;
        bus.i_a = 16'h3C00; bus.i_b = 16'h4000; bus.i_tag = 8'hA0; bus.i_valid = 1'b1;
        step();
        bus.i_tag = 8'hA1;
        step();
        bus.i_valid = 1'b0;
        chk("pre_rst_valid", 32'(bus.o_valid), 32'd1);
        rstn = 1'b0;
        step();
        chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
        chk("mid_rst_result", 32'(bus.o_result), 32'h0000);
        chk("mid_rst_tag", 32'(bus.o_tag), 32'd0);
        rstn = 1'b1;
        chk("mid_rst_rdy", 32'(bus.o_ready), 32'd1);
        repeat (6) step();
        chk("mid_rst_no_out", 32'(out_cnt - c_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
